pipeline_debug_ctrl: RTL and testbench

PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

---
 rtl/pipeline_debug_ctrl_if.sv | 35 +++
 rtl/pipeline_debug_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_debug_ctrl_if.sv
// Debug-controller bus: host byte link, instruction-memory write port,
// pipeline hold/halt and the frozen pipeline snapshot.
interface pipeline_debug_ctrl_if;
    logic         i_rx_valid;
    logic [7:0]   i_rx_data;
    logic         o_tx_valid;
    logic [7:0]   o_tx_data;
    logic         i_tx_ready;
    logic         o_we_IF;
    logic [31:0]  o_instruction_data;
    logic [7:0]   o_instruction_addr;
    logic         o_step;
    logic         i_end;
    logic         o_busy;
    logic [143:0] i_seg_id_ex;
    logic [31:0]  i_seg_ex_mem;
    logic [47:0]  i_seg_mem_wb;
    logic [39:0]  i_seg_wb_id;
    logic [23:0]  i_ctrl_id_ex;
    logic [15:0]  i_pc_lsb;

    modport slave (
        input  i_rx_valid, i_rx_data, i_tx_ready, i_end,
        input  i_seg_id_ex, i_seg_ex_mem, i_seg_mem_wb, i_seg_wb_id, i_ctrl_id_ex, i_pc_lsb,
        output o_tx_valid, o_tx_data, o_we_IF, o_instruction_data, o_instruction_addr,
        output o_step, o_busy
    );

    modport master (
        output i_rx_valid, i_rx_data, i_tx_ready, i_end,
        output i_seg_id_ex, i_seg_ex_mem, i_seg_mem_wb, i_seg_wb_id, i_ctrl_id_ex, i_pc_lsb,
        input  o_tx_valid, o_tx_data, o_we_IF, o_instruction_data, o_instruction_addr,
        input  o_step, o_busy
    );
endinterface

// File: rtl/pipeline_debug_ctrl.sv
// Host-driven pipeline debug controller: program load, run/step, snapshot dump.
// Define DEBUG_CTRL_CYCLE_COUNT_EN to append a 32-bit executed-cycle counter to the dump.
module pipeline_debug_ctrl (
    input  logic                   clk,
    input  logic                   i_reset,
    pipeline_debug_ctrl_if.slave   dbg
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_LOAD_WR = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_STEP    = 3'd4;
    localparam logic [2:0] S_DUMP    = 3'd5;

`ifdef DEBUG_CTRL_CYCLE_COUNT_EN
    localparam int SNAP_W = 336;
`else
    localparam int SNAP_W = 304;
`endif
    localparam int         NBYTES    = SNAP_W / 8;
    localparam logic [5:0] LAST_BYTE = 6'(NBYTES - 1);

    logic [2:0]        state_q, state_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [7:0]        addr_q, addr_d;
    logic              step_q, step_d;
    logic              cap_q, cap_d;
    logic              tx_valid_q, tx_valid_d;
    logic [5:0]        dcnt_q, dcnt_d;
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [SNAP_W-1:0] snap_in;
    logic              rx_fire, tx_fire;

    assign rx_fire = dbg.i_rx_valid;
    assign tx_fire = tx_valid_q & dbg.i_tx_ready;

`ifdef DEBUG_CTRL_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Counts cycles the pipeline was allowed to advance; sticks at all-ones.
    always_comb begin
        cyc_d = cyc_q;
        if (!step_q && cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (i_reset) cyc_q <= '0;
        else         cyc_q <= cyc_d;
    end

    assign snap_in = {dbg.i_seg_id_ex, dbg.i_seg_ex_mem, dbg.i_seg_mem_wb,
                      dbg.i_seg_wb_id, dbg.i_ctrl_id_ex, dbg.i_pc_lsb, cyc_q};
`else
    assign snap_in = {dbg.i_seg_id_ex, dbg.i_seg_ex_mem, dbg.i_seg_mem_wb,
                      dbg.i_seg_wb_id, dbg.i_ctrl_id_ex, dbg.i_pc_lsb};
`endif

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        bcnt_d     = bcnt_q;
        addr_d     = addr_q;
        step_d     = step_q;
        cap_d      = 1'b0;
        tx_valid_d = tx_valid_q;
        dcnt_d     = dcnt_q;
        snap_d     = snap_q;
        case (state_q)
            S_IDLE: begin
                step_d = 1'b1;
                if (rx_fire) begin
                    case (dbg.i_rx_data)
                        8'h4C: begin state_d = S_LOAD; bcnt_d = '0; end
                        // A pipeline already halted is never released.
                        8'h43: begin state_d = S_RUN;  step_d = dbg.i_end; end
                        8'h53: begin state_d = S_STEP; step_d = dbg.i_end; end
                        8'h44: begin state_d = S_DUMP; cap_d  = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (rx_fire) begin
                    word_d = {word_q[23:0], dbg.i_rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) state_d = S_LOAD_WR;
                end
            end
            S_LOAD_WR: begin
                addr_d = addr_q + 8'd4;
                bcnt_d = '0;
                if (word_q == 32'hFFFF_FFFF || addr_q == 8'd252) state_d = S_IDLE;
                else                                            state_d = S_LOAD;
            end
            S_RUN: begin
                if (dbg.i_end) begin
                    state_d = S_DUMP;
                    step_d  = 1'b1;
                    cap_d   = 1'b1;
                end
            end
            S_STEP: begin
                state_d = S_DUMP;
                step_d  = 1'b1;
                cap_d   = 1'b1;
            end
            S_DUMP: begin
                // Snapshot is taken one cycle into DUMP, once the hold has settled.
                if (cap_q) begin
                    snap_d     = snap_in;
                    tx_valid_d = 1'b1;
                    dcnt_d     = '0;
                end else if (tx_fire) begin
                    snap_d = snap_q << 8;
                    dcnt_d = dcnt_q + 6'd1;
                    if (dcnt_q == LAST_BYTE) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            bcnt_q     <= '0;
            addr_q     <= '0;
            step_q     <= 1'b1;
            cap_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            dcnt_q     <= '0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            addr_q     <= addr_d;
            step_q     <= step_d;
            cap_q      <= cap_d;
            tx_valid_q <= tx_valid_d;
            dcnt_q     <= dcnt_d;
            snap_q     <= snap_d;
        end
    end

    assign dbg.o_we_IF            = (state_q == S_LOAD_WR);
    assign dbg.o_instruction_data = word_q;
    assign dbg.o_instruction_addr = addr_q;
    assign dbg.o_step             = step_q;
    assign dbg.o_busy             = (state_q != S_IDLE);
    assign dbg.o_tx_valid         = tx_valid_q;
    assign dbg.o_tx_data          = snap_q[SNAP_W-1 -: 8];
endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed/randomized bench for pipeline_debug_ctrl against a transaction-level model.
module tb_pipeline_debug_ctrl;
`ifdef DEBUG_CTRL_CYCLE_COUNT_EN
    localparam int NB = 42;
`else
    localparam int NB = 38;
`endif

    logic clk = 1'b0;
    logic rst;
    pipeline_debug_ctrl_if bus();
    pipeline_debug_ctrl dut (.clk(clk), .i_reset(rst), .dbg(bus));

    always #5 clk = ~clk;

    int ntot = 0, npass = 0;
    logic [7:0]  txq[$];
    logic [39:0] wq[$];
    int low_cnt = 0, overlap = 0, stall_viol = 0;
    logic stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    int rdy_mode = 0;
    logic [7:0] addr_m = '0;
    int unsigned cyc_m = 0;
    logic [303:0] snap_all;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Observer: inputs change just after posedge, so at negedge both sides are settled.
    always @(negedge clk) begin
        if (bus.o_we_IF === 1'b1) wq.push_back({bus.o_instruction_addr, bus.o_instruction_data});
        if (bus.o_we_IF === 1'b1 && bus.o_tx_valid === 1'b1) overlap++;
        if (bus.o_step === 1'b0) low_cnt++;
        if (stall_prev && !(bus.o_tx_valid === 1'b1 && bus.o_tx_data === stall_data)) stall_viol++;
        if (bus.o_tx_valid === 1'b1 && bus.i_tx_ready === 1'b1) txq.push_back(bus.o_tx_data);
        stall_prev = (bus.o_tx_valid === 1'b1) && !bus.i_tx_ready && !rst;
        stall_data = bus.o_tx_data;
    end

    initial begin
        bus.i_tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.i_tx_ready = 1'b1;
                1:       bus.i_tx_ready = ~bus.i_tx_ready;
                2:       bus.i_tx_ready = 1'($urandom_range(0, 1));
                default: bus.i_tx_ready = 1'b0;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        addr_m = '0;
        cyc_m  = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < 3000) begin @(posedge clk); #1; n++; end
        chk({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    endtask

    // Model: words land at consecutive word addresses; load ends on all-ones or at 252.
    task automatic do_load(input string tag, input int nwords, input bit end_ff,
                           input logic [31:0] w0, input bit use_w0);
        logic [31:0] w;
        bit term = 1'b0;
        int i = 0;
        logic [39:0] exp_q[$];
        wq.delete();
        send_byte(8'h4C, int'($urandom_range(0, 2)));
        while (!term) begin
            if (use_w0 && i == 0)             w = w0;
            else if (end_ff && i >= nwords)   w = 32'hFFFF_FFFF;
            else begin
                w = $urandom;
                if (w == 32'hFFFF_FFFF) w = '0;
            end
            exp_q.push_back({addr_m, w});
            term = (w == 32'hFFFF_FFFF) || (addr_m == 8'd252);
            addr_m = addr_m + 8'd4;
            for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], int'($urandom_range(0, 2)));
            i++;
        end
        tick(2);
        chk({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
        chk({tag, "_nwr"}, 64'(wq.size()), 64'(exp_q.size()));
        foreach (exp_q[j]) if (j < wq.size()) chk($sformatf("%s_w%0d", tag, j), 64'(wq[j]), 64'(exp_q[j]));
    endtask

    task automatic new_snap();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        snap_all = r[303:0];
        {bus.i_seg_id_ex, bus.i_seg_ex_mem, bus.i_seg_mem_wb,
         bus.i_seg_wb_id, bus.i_ctrl_id_ex, bus.i_pc_lsb} = snap_all;
    endtask

    task automatic clear_obs();
        txq.delete();
        low_cnt    = 0;
        stall_viol = 0;
    endtask

    task automatic check_dump(input string tag, input int exp_low);
        logic [NB*8-1:0] e;
`ifdef DEBUG_CTRL_CYCLE_COUNT_EN
        e = {snap_all, cyc_m};
`else
        e = snap_all;
`endif
        wait_idle(tag);
        chk({tag, "_nbytes"}, 64'(txq.size()), 64'(NB));
        for (int j = 0; j < NB; j++)
            if (j < txq.size()) chk($sformatf("%s_b%0d", tag, j), 64'(txq[j]), 64'(e[(NB-1-j)*8 +: 8]));
        chk({tag, "_stall"}, 64'(stall_viol), 64'd0);
        chk({tag, "_lowcyc"}, 64'(low_cnt), 64'(exp_low));
        chk({tag, "_txv_end"}, 64'(bus.o_tx_valid), 64'd0);
    endtask

    task automatic do_run(input string tag, input int n);
        new_snap();
        clear_obs();
        send_byte(8'h43, 0);
        // Stray bytes during RUN must be ignored.
        for (int k = 1; k < n; k++) begin
            bus.i_rx_valid = 1'($urandom_range(0, 1));
            bus.i_rx_data  = ($urandom_range(0, 1) == 1) ? 8'h4C : 8'($urandom);
            @(posedge clk); #1;
        end
        bus.i_rx_valid = 1'b0;
        bus.i_end = 1'b1;
        @(posedge clk); #1;
        bus.i_end = 1'b0;
        cyc_m += n;
        check_dump(tag, n);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;
        bus.i_end      = 1'b0;
        new_snap();
        do_reset();
        rst = 1'b1;
        tick(1);
        chk("rst_step",  64'(bus.o_step), 64'd1);
        chk("rst_we",    64'(bus.o_we_IF), 64'd0);
        chk("rst_idata", 64'(bus.o_instruction_data), 64'd0);
        chk("rst_iaddr", 64'(bus.o_instruction_addr), 64'd0);
        chk("rst_txv",   64'(bus.o_tx_valid), 64'd0);
        chk("rst_txd",   64'(bus.o_tx_data), 64'd0);
        chk("rst_busy",  64'(bus.o_busy), 64'd0);
        rst = 1'b0;
        tick(1);

        for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 1);
        chk("idle_junk_busy", 64'(bus.o_busy), 64'd0);

        do_load("load_dir", 1, 1'b1, 32'h0000_0001, 1'b1);
        do_load("load_rnd", int'($urandom_range(1, 4)), 1'b1, '0, 1'b0);

        wq.delete();
        send_byte(8'h4C, 0);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        do_reset();
        tick(3);
        chk("rstload_busy", 64'(bus.o_busy), 64'd0);
        chk("rstload_nwr",  64'(wq.size()), 64'd0);
        do_load("load_after_rst", 2, 1'b1, '0, 1'b0);
        do_load("load_to_252", 0, 1'b0, '0, 1'b0);
        do_load("load_wrap", 1, 1'b1, '0, 1'b0);

        new_snap();
        clear_obs();
        rdy_mode = 0;
        send_byte(8'h53, 0);
        cyc_m += 1;
        check_dump("step", 1);

        new_snap();
        clear_obs();
        rdy_mode = 1;
        send_byte(8'h44, 0);
        send_byte(8'h4C, 0);
        check_dump("dump_toggle", 0);

        rdy_mode = 2;
        do_run("run10", 10);
        do_run("run_rnd", int'($urandom_range(3, 20)));

        new_snap();
        clear_obs();
        bus.i_end = 1'b1;
        send_byte(8'h53, 0);
        check_dump("step_halted", 0);
        bus.i_end = 1'b0;

        rdy_mode = 3;
        new_snap();
        send_byte(8'h44, 0);
        tick(5);
        chk("rstdump_txv_pre", 64'(bus.o_tx_valid), 64'd1);
        do_reset();
        chk("rstdump_txv",  64'(bus.o_tx_valid), 64'd0);
        chk("rstdump_busy", 64'(bus.o_busy), 64'd0);
        chk("rstdump_step", 64'(bus.o_step), 64'd1);
        chk("rstdump_txd",  64'(bus.o_tx_data), 64'd0);
        rdy_mode = 0;

        new_snap();
        clear_obs();
        send_byte(8'h53, 0);
        cyc_m += 1;
        check_dump("step_after_rst", 1);

        chk("we_tx_overlap", 64'(overlap), 64'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
